dcache_ctrl: RTL and testbench
==============================

DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 The module SHALL have a single clock and a synchronous, active-high reset: clock is the single clock, reset is synchronous and active-high.
REQ-002 Parameters SHALL be LINES, default 16, number of direct-mapped lines; and WORDS, default 4, 32-bit words per line.
REQ-003 Ports:
- clock, input, 1: rising-edge clock.
- reset, input, 1: synchronous active-high reset.
- cpu_req, input, 1: MEM-stage access request, level, held until cpu_ready.
- cpu_we, input, 1: 1 = store, 0 = load.
- cpu_addr, input, 32: byte address; bits [1:0] ignored.
- cpu_wdata, input, 32: store data.
- cpu_rdata, output, 32: load data, valid while cpu_ready=1.
- cpu_ready, output, 1: one-cycle completion pulse.
- cpu_busy, output, 1: high from acceptance until cpu_ready; drives the pipeline stall.
- flush, input, 1: invalidate all lines.
- mem_req, output, 1: backing-memory request, level.
- mem_we, output, 1: backing-memory write.
- mem_addr, output, 32: word-aligned backing-memory address.
- mem_wdata, output, 32: backing-memory write data.
- mem_rdata, input, 32: backing-memory read data, valid with mem_ack.
- mem_ack, input, 1: one-cycle completion of the current mem_req.
- hit_count, output, 16: saturating count of read hits.
- miss_count, output, 16: saturating count of read misses.

Function
REQ-004 Address split SHALL be: offset = addr[3:2], index = addr[7:4], tag = addr[31:8] (defaults; widths derive from the parameters).
REQ-005 Policy SHALL be write-through, no-write-allocate, direct-mapped.
REQ-006 FSM states SHALL be IDLE, LOOKUP, REFILL, WRITE, DONE.
REQ-007 In IDLE with cpu_req=1 and flush=0, the module SHALL latch addr/we/wdata and go to LOOKUP; cpu_busy=1 from the next cycle.
REQ-008 In LOOKUP:
- load hit (valid and tag equal) -> DONE with the word captured, hit_count+1;
- load miss -> REFILL, word counter=0, miss_count+1;
- store -> WRITE.
REQ-009 In REFILL, mem_req=1 and mem_we=0, with mem_addr = {tag, index, cnt, 2'b00}; each mem_ack SHALL write mem_rdata into word cnt and increment cnt.
REQ-010 On the WORDS-th ack, REFILL SHALL set the line's valid bit and tag, capture the requested word, and go to DONE.
REQ-011 In WRITE, mem_req=1, mem_we=1, mem_addr = latched addr[31:2]<<2 and mem_wdata = latched wdata; on mem_ack, if the line hits, the word SHALL be updated; next state DONE.
REQ-012 In DONE, cpu_ready=1 for exactly one cycle with cpu_rdata valid for loads (don't-care for stores); next state IDLE.
REQ-013 Load-hit latency SHALL be 2 cycles from the acceptance edge to cpu_ready.
REQ-014 Load-miss latency SHALL be 2 + the sum of memory wait cycles + WORDS.
REQ-015 mem_req SHALL stay high with stable mem_addr, mem_we and mem_wdata until mem_ack.
REQ-016 mem_ack SHALL be ignored when mem_req=0.
REQ-017 flush in IDLE SHALL clear all valid bits in one cycle and take priority over a simultaneous cpu_req, which is accepted the following cycle if still held.
REQ-018 flush outside IDLE SHALL be ignored.
REQ-019 The next request SHALL NOT be accepted in the DONE cycle; earliest acceptance is the cycle after cpu_ready.
REQ-020 hit_count and miss_count SHALL saturate at 16'hFFFF and not wrap.
REQ-021 A read immediately after a store to the same address SHALL return the stored data (hit: cache updated; miss: refill fetches the written-through value).

Reset
REQ-022 On reset the FSM SHALL enter IDLE, and all valid bits, cnt, hit_count, miss_count, cpu_ready, cpu_busy, mem_req, mem_we and cpu_rdata SHALL clear to 0; mem_addr and mem_wdata SHALL be 0.
REQ-023 Reset mid-REFILL or mid-WRITE SHALL abort the operation: mem_req=0 the cycle after reset is sampled, the partial line stays invalid, and no cpu_ready is issued.
REQ-024 Data and tag array contents SHALL NOT require reset.

Structure
REQ-025 A shared package SHALL hold the FSM state encoding, the LINES/WORDS defaults, and the derived OFFSET_W/INDEX_W/TAG_W constants.
REQ-026 The data store SHALL be a sub-module dcache_data_array (LINES*WORDS x 32, one write port, one async read port); tags and valid bits stay in dcache_ctrl.

Verification
REQ-027 Bench SHALL use a memory model with a configurable ack delay, default 3 wait cycles.
REQ-028 Directed scenarios:
- Cold load at 0x00000104, Mem word 0x00000104=0xDEADBEEF -> four mem reads 0x100..0x10C, cpu_ready at cycle 18 after acceptance, rdata 0xDEADBEEF, miss_count=1.
- Repeat load at 0x00000104 -> no mem_req, cpu_ready 2 cycles after acceptance, hit_count=1.
- Store 0x12345678 to 0x00000108 (hit) then load 0x108 -> one mem write with mem_wdata 0x12345678, load hits and returns 0x12345678.
- Load 0x00001104 after line 0 filled from 0x100 (same index, different tag) -> refill, miss_count+1, then load 0x104 misses again.
- flush and cpu_req asserted together in IDLE -> all valid cleared, request accepted next cycle, and a load of a prior hit address misses.
- reset asserted during the 2nd refill word -> mem_req=0 next cycle, no cpu_ready, and a subsequent load to the same line misses.

Source files
------------

// File: rtl/dcache_pkg.sv
// dcache_pkg: shared FSM encoding, geometry defaults and derived field widths.
package dcache_pkg;
    localparam int LINES_DEF = 16;
    localparam int WORDS_DEF = 4;
    localparam int OFFSET_W = $clog2(WORDS_DEF);
    localparam int INDEX_W = $clog2(LINES_DEF);
    localparam int TAG_W = 30 - OFFSET_W - INDEX_W;
    typedef enum logic [2:0] {IDLE, LOOKUP, REFILL, WRITE, DONE} state_t;
endpackage

// File: rtl/dcache_data_array.sv
// dcache_data_array: LINES*WORDS x 32 data store, one sync write port, one async read port.
// Ports: clock; we/waddr/wdata write port; raddr/rdata combinational read port.
module dcache_data_array
    import dcache_pkg::*;
#(
    parameter int LINES = LINES_DEF,
    parameter int WORDS = WORDS_DEF,
    localparam int AW = $clog2(LINES * WORDS)
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);
    logic [31:0] mem [LINES*WORDS];
    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
    end
    assign rdata = mem[raddr];
endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-through, no-write-allocate data cache controller.
// Ports: clock/reset; cpu_* MEM-stage request/response with busy stall; flush invalidates
// all lines in IDLE; mem_* level request to backing memory completed by a one-cycle mem_ack;
// hit_count/miss_count saturating read hit/miss counters.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int LINES = LINES_DEF,
    parameter int WORDS = WORDS_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ready,
    output logic        cpu_busy,
    input  logic        flush,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
);
    localparam int OW = $clog2(WORDS);
    localparam int IW = $clog2(LINES);
    localparam int TW = 30 - OW - IW;

    state_t state, next;
    logic [29:0] addr_q;
    logic we_q;
    logic [31:0] wdata_q;
    logic [TW-1:0] tags [LINES];
    logic [LINES-1:0] valid;
    logic [OW-1:0] cnt;
    logic [TW-1:0] tag;
    logic [IW-1:0] idx;
    logic [OW-1:0] off;
    logic hit, last, accept, arr_we;
    logic [31:0] arr_rdata;
    logic unused_addr_bits;

    assign unused_addr_bits = ^cpu_addr[1:0];
    assign tag = addr_q[29 -: TW];
    assign idx = addr_q[OW +: IW];
    assign off = addr_q[OW-1:0];
    assign hit = valid[idx] && tags[idx] == tag;
    assign last = cnt == OW'(WORDS - 1);
    assign accept = state == IDLE && cpu_req && !flush;

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = accept ? LOOKUP : IDLE;
            LOOKUP:  next = we_q ? WRITE : (hit ? DONE : REFILL);
            REFILL:  next = (mem_ack && last) ? DONE : REFILL;
            WRITE:   next = mem_ack ? DONE : WRITE;
            default: next = IDLE;
        endcase
    end

    always_comb begin
        cpu_ready = state == DONE;
        cpu_busy = state != IDLE;
        mem_req = state == REFILL || state == WRITE;
        mem_we = state == WRITE;
        mem_addr = state == REFILL ? {tag, idx, cnt, 2'b00} : (state == WRITE ? {addr_q, 2'b00} : 32'd0);
        mem_wdata = state == WRITE ? wdata_q : 32'd0;
        // store updates the cached word only when the line already holds it
        arr_we = mem_ack && (state == REFILL || (state == WRITE && hit));
    end

    dcache_data_array #(.LINES(LINES), .WORDS(WORDS)) u_data (
        .clock(clock),
        .we(arr_we),
        .waddr({idx, state == REFILL ? cnt : off}),
        .wdata(state == REFILL ? mem_rdata : wdata_q),
        .raddr({idx, off}),
        .rdata(arr_rdata)
    );

    always_ff @(posedge clock) begin
        if (accept) begin
            addr_q <= cpu_addr[31:2];
            we_q <= cpu_we;
            wdata_q <= cpu_wdata;
        end
        if (!reset && state == REFILL && mem_ack && last) tags[idx] <= tag;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            valid <= '0;
            cnt <= '0;
            hit_count <= '0;
            miss_count <= '0;
            cpu_rdata <= '0;
        end else begin
            state <= next;
            if (state == IDLE && flush) valid <= '0;
            if (state == LOOKUP && !we_q) begin
                if (hit) begin
                    cpu_rdata <= arr_rdata;
                    hit_count <= hit_count + 16'(hit_count != 16'hFFFF);
                end else begin
                    // invalidate up front so a partially refilled line never looks valid
                    valid[idx] <= 1'b0;
                    cnt <= '0;
                    miss_count <= miss_count + 16'(miss_count != 16'hFFFF);
                end
            end
            if (state == REFILL && mem_ack) begin
                cnt <= cnt + 1'b1;
                if (cnt == off) cpu_rdata <= mem_rdata;
                if (last) valid[idx] <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: scoreboard bench for dcache_ctrl with a fixed-delay backing memory model.
module tb_dcache_ctrl;
    localparam int ACK_DELAY = 3;

    typedef struct {
        logic [31:0] rdata;
        logic chk;
        int start;
        int lat;
    } item_t;

    logic clock = 0, reset = 1;
    logic cpu_req = 0, cpu_we = 0, flush = 0;
    logic [31:0] cpu_addr = 0, cpu_wdata = 0;
    logic [31:0] cpu_rdata, mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 0;
    logic cpu_ready, cpu_busy, mem_req, mem_we;
    logic mem_ack = 0;
    logic [15:0] hit_count, miss_count;

    int n_cmp = 0, n_err = 0, cyc = 0;
    item_t sb[$];
    logic [31:0] mem [logic [31:0]];
    logic [31:0] rd_log[$], wr_addr_log[$], wr_data_log[$];

    dcache_ctrl dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_busy(cpu_busy), .flush(flush),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : ~a;
    endfunction

    // memory model: ACK_DELAY wait cycles, then a one-cycle ack; also checks request hold
    initial begin
        int wait_cnt = 0;
        logic p_req = 0;
        logic [31:0] p_addr = 0, p_wdata = 0;
        forever begin
            @(negedge clock);
            if (mem_req && p_req && !mem_ack) begin
                check("mem_addr_hold", mem_addr, p_addr);
                check("mem_wdata_hold", mem_wdata, p_wdata);
            end
            p_req = mem_req;
            p_addr = mem_addr;
            p_wdata = mem_wdata;
            mem_ack = 0;
            if (!mem_req || reset) wait_cnt = 0;
            else if (wait_cnt == ACK_DELAY) begin
                mem_ack = 1;
                wait_cnt = 0;
                if (mem_we) begin
                    mem[mem_addr] = mem_wdata;
                    wr_addr_log.push_back(mem_addr);
                    wr_data_log.push_back(mem_wdata);
                end else begin
                    mem_rdata = rd_word(mem_addr);
                    rd_log.push_back(mem_addr);
                end
            end else wait_cnt++;
        end
    end

    initial begin
        item_t it;
        forever begin
            @(negedge clock);
            if (cpu_ready) begin
                if (sb.size() == 0) check("spurious_ready", 32'd1, 32'd0);
                else begin
                    it = sb.pop_front();
                    check("latency", 32'(cyc - it.start), 32'(it.lat));
                    if (it.chk) check("rdata", cpu_rdata, it.rdata);
                end
            end
        end
    end

    task automatic access(input logic we, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp, input int lat, input logic fl);
        item_t it;
        int n;
        bit done;
        @(negedge clock);
        cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d; flush = fl;
        it.rdata = exp; it.chk = !we; it.start = cyc; it.lat = lat;
        sb.push_back(it);
        n = 0; done = 0;
        while (!done && n < 200) begin
            @(negedge clock);
            flush = 0;
            n++;
            if (cpu_ready) done = 1;
        end
        cpu_req = 0;
        if (!done) begin
            check("ready_timeout", 32'd0, 32'd1);
            if (sb.size() != 0) void'(sb.pop_front());
        end
    endtask

    initial begin
        int base, n;
        mem[32'h104] = 32'hDEADBEEF;
        repeat (2) @(negedge clock);
        reset = 0;
        @(negedge clock);
        check("rst_ready", {31'd0, cpu_ready}, 0);
        check("rst_busy", {31'd0, cpu_busy}, 0);
        check("rst_mem_req", {31'd0, mem_req}, 0);
        check("rst_mem_we", {31'd0, mem_we}, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_rdata", cpu_rdata, 0);
        check("rst_hits", {16'd0, hit_count}, 0);
        check("rst_misses", {16'd0, miss_count}, 0);

        // cold load miss
        access(0, 32'h104, 0, 32'hDEADBEEF, 18, 0);
        check("cold_reads", rd_log.size(), 4);
        for (int i = 0; i < 4 && i < rd_log.size(); i++)
            check("cold_read_addr", rd_log[i], 32'h100 + 32'(4 * i));
        check("cold_misses", {16'd0, miss_count}, 1);
        check("cold_hits", {16'd0, hit_count}, 0);

        // repeat load hits, no memory traffic
        base = rd_log.size();
        access(0, 32'h104, 0, 32'hDEADBEEF, 2, 0);
        check("hit_no_reads", rd_log.size(), base);
        check("hit_hits", {16'd0, hit_count}, 1);

        // store hit, then load sees new data
        access(1, 32'h108, 32'h12345678, 0, 6, 0);
        check("store_writes", wr_addr_log.size(), 1);
        if (wr_addr_log.size() == 1) begin
            check("store_addr", wr_addr_log[0], 32'h108);
            check("store_data", wr_data_log[0], 32'h12345678);
        end
        access(0, 32'h108, 0, 32'h12345678, 2, 0);
        check("st_ld_hits", {16'd0, hit_count}, 2);

        // conflict on index 0
        access(0, 32'h1104, 0, ~32'h1104, 18, 0);
        check("conf_misses", {16'd0, miss_count}, 2);
        access(0, 32'h104, 0, 32'hDEADBEEF, 18, 0);
        check("conf_back_misses", {16'd0, miss_count}, 3);

        // flush together with a request: accepted one cycle later, then misses
        access(0, 32'h104, 0, 32'hDEADBEEF, 19, 1);
        check("flush_misses", {16'd0, miss_count}, 4);
        check("flush_hits", {16'd0, hit_count}, 2);

        // store miss is not allocated; the following load refills the written value
        access(1, 32'h208, 32'hCAFEF00D, 0, 6, 0);
        access(0, 32'h208, 0, 32'hCAFEF00D, 18, 0);
        check("stmiss_misses", {16'd0, miss_count}, 5);

        // reset during the second refill word
        base = rd_log.size();
        @(negedge clock);
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h304;
        n = 0;
        while (rd_log.size() == base && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("abort_first_word", rd_log.size(), base + 1);
        @(negedge clock);
        reset = 1; cpu_req = 0;
        @(negedge clock);
        reset = 0;
        check("abort_mem_req", {31'd0, mem_req}, 0);
        check("abort_busy", {31'd0, cpu_busy}, 0);
        repeat (25) @(negedge clock);
        check("abort_reads", rd_log.size(), base + 1);
        check("abort_misses", {16'd0, miss_count}, 0);
        access(0, 32'h304, 0, ~32'h304, 18, 0);
        check("abort_reload_misses", {16'd0, miss_count}, 1);
        check("abort_reload_hits", {16'd0, hit_count}, 0);

        repeat (3) @(negedge clock);
        check("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
